// File: rtl/fp32_pkg.sv
// fp32_pkg: shared types and constants for the binary32 normalise/round/pack stage.
//   BIAS, EXP_MAX, QNAN   - format constants
//   fp32_t                - packed binary32 view {sign, exp, man}
//   fp_class_e            - operand class (ZERO/NORM/INF/NAN); sNaN carried as a separate bit
//   exp_t                 - 10-bit signed exponent used for all range checks
//   s1_t                  - stage-1 pipeline register contents
package fp32_pkg;

    localparam int unsigned BIAS    = 127;
    localparam int unsigned EXP_MAX = 255;
    localparam logic [31:0] QNAN    = 32'h7FC0_0000;

    typedef struct packed {
        logic        sign;
        logic [7:0]  exp;
        logic [22:0] man;
    } fp32_t;

    typedef enum logic [1:0] {
        ZERO,
        NORM,
        INF,
        NAN
    } fp_class_e;

    typedef logic signed [9:0] exp_t;

    typedef struct packed {
        logic        valid;
        fp_class_e   cls_a;
        logic        snan_a;
        fp_class_e   cls_b;
        logic        snan_b;
        logic        sign;
        exp_t        e;
        logic [22:0] m;
        logic        g;
        logic        s;
    } s1_t;

endpackage

// File: rtl/fp32_classify.sv
// fp32_classify: combinational binary32 operand classifier.
//   op_i      in  31  exponent and mantissa bits of the operand (sign not needed)
//   cls_o     out     ZERO (incl. flushed subnormals), NORM, INF or NAN
//   is_snan_o out  1  operand is a signalling NaN (quiet bit clear)
module fp32_classify
    import fp32_pkg::*;
(
    input  logic [30:0] op_i,
    output fp_class_e   cls_o,
    output logic        is_snan_o
);

    logic [7:0]  e_f;
    logic [22:0] m_f;

    always_comb begin
        e_f       = op_i[30:23];
        m_f       = op_i[22:0];
        cls_o     = NORM;
        is_snan_o = 1'b0;
        if (e_f == 8'd0) begin
            cls_o = ZERO;
        end else if (e_f == 8'hFF) begin
            if (m_f == '0) begin
                cls_o = INF;
            end else begin
                cls_o     = NAN;
                is_snan_o = !m_f[22];
            end
        end
    end

endmodule

// File: rtl/fp32_mul_round.sv
// fp32_mul_round: 2-stage normalise/round/pack back end of the binary32 multiplier.
//   clk, rst_n           clock, asynchronous active-low reset
//   in_valid/in_ready    input handshake for op_a, op_b, prod
//   op_a, op_b  [31:0]   original operands
//   prod        [47:0]   raw product {1,ma}*{1,mb}
//   out_valid/out_ready  output handshake for result, flags
//   result      [31:0]   round-to-nearest-even binary32 product
//   flags       [3:0]    {nv, of, uf, nx}
module fp32_mul_round
    import fp32_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] op_a,
    input  logic [31:0] op_b,
    input  logic [47:0] prod,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] result,
    output logic [3:0]  flags
);

    fp_class_e   cls_a, cls_b;
    logic        snan_a, snan_b;

    s1_t         s1_d, s1_q;
    exp_t        e_sum;

    logic        en;
    logic        out_valid_q;
    logic [31:0] result_q;
    logic [3:0]  flags_q;

    logic        rnd_up, carry;
    logic [22:0] m_rnd;
    exp_t        e_pre, e_rnd;
    logic        any_nan, any_inf, any_zero, inf_x_zero;
    fp32_t       res_d;
    logic [3:0]  flg_d;

    fp32_classify u_cls_a (.op_i(op_a[30:0]), .cls_o(cls_a), .is_snan_o(snan_a));
    fp32_classify u_cls_b (.op_i(op_b[30:0]), .cls_o(cls_b), .is_snan_o(snan_b));

    // Whole pipeline advances together; it only freezes when the output is held.
    assign en       = !out_valid_q | out_ready;
    assign in_ready = en;

    // Stage 1: exponent sum and normalisation of the raw product.
    always_comb begin
        e_sum       = exp_t'({2'b00, op_a[30:23]}) + exp_t'({2'b00, op_b[30:23]}) - exp_t'(BIAS);
        s1_d        = '0;
        s1_d.valid  = in_valid;
        s1_d.cls_a  = cls_a;
        s1_d.snan_a = snan_a;
        s1_d.cls_b  = cls_b;
        s1_d.snan_b = snan_b;
        s1_d.sign   = op_a[31] ^ op_b[31];
        if (prod[47]) begin
            s1_d.m = prod[46:24];
            s1_d.g = prod[23];
            s1_d.s = |prod[22:0];
            s1_d.e = e_sum + 10'sd1;
        end else begin
            s1_d.m = prod[45:23];
            s1_d.g = prod[22];
            s1_d.s = |prod[21:0];
            s1_d.e = e_sum;
        end
    end

    // Stage 2: round, range check, then specials override the arithmetic result.
    always_comb begin
        e_pre           = s1_q.e;
        rnd_up          = s1_q.g & (s1_q.s | s1_q.m[0]);
        {carry, m_rnd}  = {1'b0, s1_q.m} + {23'd0, rnd_up};
        e_rnd           = e_pre + exp_t'({9'd0, carry});

        any_nan    = (s1_q.cls_a == NAN)  || (s1_q.cls_b == NAN);
        any_inf    = (s1_q.cls_a == INF)  || (s1_q.cls_b == INF);
        any_zero   = (s1_q.cls_a == ZERO) || (s1_q.cls_b == ZERO);
        inf_x_zero = any_inf && any_zero;

        res_d = '{sign: s1_q.sign, exp: e_rnd[7:0], man: m_rnd};
        flg_d = {3'b000, s1_q.g | s1_q.s};

        // Tininess is judged on the pre-round exponent; overflow on the rounded one.
        if (e_pre <= exp_t'(0)) begin
            res_d = '{sign: s1_q.sign, exp: 8'h00, man: 23'h0};
            flg_d = 4'b0011;
        end else if (e_rnd >= exp_t'(EXP_MAX)) begin
            res_d = '{sign: s1_q.sign, exp: 8'hFF, man: 23'h0};
            flg_d = 4'b0101;
        end

        if (any_nan || inf_x_zero) begin
            res_d = QNAN;
            flg_d = {s1_q.snan_a | s1_q.snan_b | inf_x_zero, 3'b000};
        end else if (any_inf) begin
            res_d = '{sign: s1_q.sign, exp: 8'hFF, man: 23'h0};
            flg_d = 4'b0000;
        end else if (any_zero) begin
            res_d = '{sign: s1_q.sign, exp: 8'h00, man: 23'h0};
            flg_d = 4'b0000;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_q        <= '0;
            out_valid_q <= 1'b0;
            result_q    <= '0;
            flags_q     <= '0;
        end else if (en) begin
            s1_q        <= s1_d;
            out_valid_q <= s1_q.valid;
            if (s1_q.valid) begin
                result_q <= res_d;
                flags_q  <= flg_d;
            end
        end
    end

    assign out_valid = out_valid_q;
    assign result    = result_q;
    assign flags     = flags_q;

endmodule

// File: tb/tb_fp32_mul_round.sv
// tb_fp32_mul_round: randomized and directed self-checking bench for fp32_mul_round.
// A value-level reference model predicts {flags, result} for every accepted input;
// one compare process matches outputs in order and checks the handshake rules.
module tb_fp32_mul_round;
    import fp32_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] op_a = '0;
    logic [31:0] op_b = '0;
    logic [47:0] prod = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] result;
    logic [3:0]  flags;

    fp32_mul_round dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op_a      (op_a),
        .op_b      (op_b),
        .prod      (prod),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .flags     (flags)
    );

    always #5 clk = ~clk;

    int          n_cmp = 0;
    int          n_bad = 0;
    int          n_out = 0;
    int          cyc = 0;
    int          orm = 0;      // out_ready mode: 0 always, 1 random, 2 backpressure window
    int          bp_start = 0;
    logic [35:0] exp_q[$];
    logic        stall_p = 1'b0;
    logic [36:0] held = '0;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [47:0] p;
        logic [35:0] want;
    } vec_t;
    vec_t dv[$];

    task automatic check(input string name, input logic [39:0] act, input logic [39:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %h, required %h", name, act, req);
        end
    endtask

    // Reference: exact integer rounding of the product, returns {flags, result}.
    function automatic logic [35:0] model(input logic [31:0] a, input logic [31:0] b,
                                          input logic [47:0] p);
        int ea = int'(a[30:23]);
        int eb = int'(b[30:23]);
        bit za = (ea == 0);
        bit zb = (eb == 0);
        bit ia = (ea == 255) && (a[22:0] == 0);
        bit ib = (eb == 255) && (b[22:0] == 0);
        bit na = (ea == 255) && (a[22:0] != 0);
        bit nb = (eb == 255) && (b[22:0] != 0);
        bit sa = na && !a[22];
        bit sb = nb && !b[22];
        bit sg = a[31] ^ b[31];
        bit ixz = (ia && zb) || (za && ib);
        int e, sh;
        longint unsigned mant, rem, half;
        bit up, inx;
        if (na || nb || ixz) return {(sa || sb || ixz), 3'b000, 32'h7FC0_0000};
        if (ia || ib) return {4'b0000, sg, 8'hFF, 23'h0};
        if (za || zb) return {4'b0000, sg, 31'h0};
        sh   = p[47] ? 24 : 23;
        e    = ea + eb - 127 + (p[47] ? 1 : 0);
        mant = {16'h0, p} >> sh;
        rem  = {16'h0, p} & ((64'd1 << sh) - 64'd1);
        half = 64'd1 << (sh - 1);
        up   = (rem > half) || ((rem == half) && mant[0]);
        inx  = (rem != 0);
        if (e <= 0) return {4'b0011, sg, 31'h0};
        mant = mant + longint'(up);
        if (mant >= (64'd1 << 24)) begin
            mant = mant >> 1;
            e++;
        end
        if (e >= 255) return {4'b0101, sg, 8'hFF, 23'h0};
        return {3'b000, inx, sg, e[7:0], mant[22:0]};
    endfunction

    function automatic logic [47:0] real_prod(input logic [31:0] a, input logic [31:0] b);
        return 48'({1'b1, a[22:0]}) * 48'({1'b1, b[22:0]});
    endfunction

    function automatic logic [31:0] rand_op();
        int          k = $urandom_range(0, 19);
        logic [22:0] m = 23'($urandom);
        logic [7:0]  e;
        case (k)
            0:       e = 8'd0;
            1:       begin e = 8'hFF; m = '0; end
            2:       begin e = 8'hFF; m[0] = 1'b1; end
            3:       e = 8'($urandom_range(1, 20));
            4:       e = 8'($urandom_range(235, 254));
            5, 6:    e = 8'($urandom_range(55, 72));
            default: e = 8'($urandom_range(90, 165));
        endcase
        return {1'($urandom), e, m};
    endfunction

    task automatic send(input logic [31:0] a, input logic [31:0] b, input logic [47:0] p);
        int guard = 0;
        @(negedge clk);
        op_a = a;
        op_b = b;
        prod = p;
        in_valid = 1'b1;
        #1;
        while (!in_ready && guard < 200) begin
            @(negedge clk);
            #1;
            guard++;
        end
        if (!in_ready) begin
            n_cmp++;
            n_bad++;
            $display("FAIL send_timeout: in_ready=0 after 200 cycles, required 1");
            in_valid = 1'b0;
        end else begin
            @(posedge clk);
        end
    endtask

    task automatic idle();
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int guard = 0;
        orm = 0;
        while ((exp_q.size() != 0 || out_valid) && guard < 300) begin
            @(negedge clk);
            #3;
            guard++;
        end
        n_cmp++;
        if (guard >= 300) begin
            n_bad++;
            $display("FAIL drain_timeout: %0d results outstanding, required 0", exp_q.size());
        end
    endtask

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        case (orm)
            1:       out_ready = ($urandom_range(0, 3) != 0);
            2:       out_ready = !((cyc >= bp_start + 3) && (cyc <= bp_start + 6));
            default: out_ready = 1'b1;
        endcase
    end

    // Compare process: samples between edges the handshakes that the next rising edge performs.
    always @(negedge clk) begin
        #2;
        if (!rst_n) begin
            exp_q.delete();
            stall_p = 1'b0;
        end else begin
            check("in_ready_rule", 40'(in_ready), 40'(!out_valid || out_ready));
            if (stall_p) check("hold_stable", 40'({out_valid, flags, result}), 40'(held));
            if (in_valid && in_ready) exp_q.push_back(model(op_a, op_b, prod));
            if (out_valid && out_ready) begin
                n_out++;
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL spurious_out: got %h/%h, required no output", flags, result);
                end else begin
                    check("result", 40'({flags, result}), 40'(exp_q.pop_front()));
                end
            end
            stall_p = out_valid && !out_ready;
            held    = {out_valid, flags, result};
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int snap;

        dv.push_back('{32'h3FC00000, 32'h40000000, 48'h6000_0000_0000, {4'b0000, 32'h40400000}});
        dv.push_back('{32'h3F800000, 32'h3F800000, 48'h4000_00C0_0000, {4'b0001, 32'h3F800002}});
        dv.push_back('{32'h3F800000, 32'h3F800000, 48'h4000_0040_0000, {4'b0001, 32'h3F800000}});
        dv.push_back('{32'h3F800000, 32'h3F800000, 48'h7FFF_FFFF_FFFF, {4'b0001, 32'h40000000}});
        dv.push_back('{32'h7F000000, 32'h40000000, 48'h4000_0000_0000, {4'b0101, 32'h7F800000}});
        dv.push_back('{32'h0D800000, 32'h0D800000, 48'h4000_0000_0000, {4'b0011, 32'h00000000}});
        dv.push_back('{32'h7F800000, 32'h00000000, 48'h1234_5678_9ABC, {4'b1000, 32'h7FC00000}});
        dv.push_back('{32'h80000000, 32'h40A00000, 48'h4000_0000_0000, {4'b0000, 32'h80000000}});
        dv.push_back('{32'h7FA00000, 32'h3F800000, 48'h4000_0000_0000, {4'b1000, 32'h7FC00000}});
        dv.push_back('{32'hFF800000, 32'h40000000, 48'h4000_0000_0000, {4'b0000, 32'hFF800000}});
        dv.push_back('{32'h7F000000, 32'h3F800000, 48'h7FFF_FFFF_FFFF, {4'b0101, 32'h7F800000}});
        dv.push_back('{32'h20000000, 32'h1F800000, 48'h7FFF_FFFF_FFFF, {4'b0011, 32'h00000000}});
        dv.push_back('{32'h20000000, 32'h20000000, 48'h4000_0000_0000, {4'b0000, 32'h00800000}});
        dv.push_back('{32'h7FC00001, 32'h7F800000, 48'h0, {4'b0000, 32'h7FC00000}});
        dv.push_back('{32'hBFC00000, 32'h40000000, 48'h6000_0000_0000, {4'b0000, 32'hC0400000}});

        #1;
        check("reset_state", 40'({in_ready, out_valid, flags, result}), 40'({1'b1, 37'h0}));
        repeat (2) @(negedge clk);
        #3 rst_n = 1'b1;
        @(negedge clk);
        #1 check("ready_after_reset", 40'(in_ready), 40'(1));

        foreach (dv[i]) check($sformatf("model_pin%0d", i), 40'(model(dv[i].a, dv[i].b, dv[i].p)),
                              40'(dv[i].want));

        // First item into an empty pipeline: valid after the second rising edge.
        send(dv[0].a, dv[0].b, dv[0].p);
        #1 check("latency_edge1", 40'(out_valid), 40'(0));
        idle();
        @(posedge clk);
        #1 check("latency_edge2", 40'({out_valid, flags, result}), 40'({1'b1, dv[0].want}));
        for (int i = 1; i < dv.size(); i++) send(dv[i].a, dv[i].b, dv[i].p);
        idle();
        drain();

        // Backpressure window on out_ready.
        snap = n_out;
        bp_start = cyc;
        orm = 2;
        fork
            begin
                for (int i = 0; i < 4; i++) begin
                    logic [31:0] bb = 32'h40000000 + (i << 20);
                    send(32'h3FC00000, bb, real_prod(32'h3FC00000, bb));
                end
                idle();
            end
            begin
                repeat (5) @(posedge clk);
                @(negedge clk);
                #1 check("bp_stalled", 40'({in_ready, out_valid}), 40'(2'b01));
            end
        join
        drain();
        check("bp_count", 40'(n_out - snap), 40'(4));

        // Reset with two items in flight.
        send(32'h3FC00000, 32'h40000000, 48'h6000_0000_0000);
        send(32'h40400000, 32'h40400000, real_prod(32'h40400000, 32'h40400000));
        snap = n_out;
        #2;
        rst_n = 1'b0;
        in_valid = 1'b0;
        #1 check("reset_async", 40'(out_valid), 40'(0));
        repeat (2) @(negedge clk);
        #3 rst_n = 1'b1;
        @(negedge clk);
        #1 check("ready_after_midreset", 40'(in_ready), 40'(1));
        repeat (4) @(negedge clk);
        #3 check("no_stale_output", 40'(n_out - snap), 40'(0));
        send(32'h40000000, 32'h40000000, 48'h4000_0000_0000);
        idle();
        drain();
        check("post_reset_count", 40'(n_out - snap), 40'(1));

        // Randomized stream with random output backpressure.
        orm = 1;
        for (int i = 0; i < 400; i++) begin
            logic [31:0] ra = rand_op();
            logic [31:0] rb = rand_op();
            logic [47:0] rp;
            if ($urandom_range(0, 9) != 0) begin
                rp = real_prod(ra, rb);
            end else begin
                rp = {16'($urandom), $urandom};
                rp[46] = 1'b1;
            end
            if ($urandom_range(0, 9) == 0) idle();
            send(ra, rb, rp);
        end
        idle();
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
